// File: rtl/expr_eval_engine.sv
`default_nettype none
// ============================================================================
// expr_eval_engine : streaming shunting-yard evaluator for signed integer expressions
// Revision 1.0
// ============================================================================
module expr_eval_engine #(
   parameter int DATA_W   = 32,
   parameter int VSTACK_D = 16,
   parameter int OSTACK_D = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              abort,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic [2:0]        tok_kind,
   input  logic [3:0]        tok_op,
   input  logic [DATA_W-1:0] tok_num,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [2:0]        res_err
);

   localparam int VPW = $clog2(VSTACK_D + 1);
   localparam int OPW = $clog2(OSTACK_D + 1);
   localparam int VAW = (VSTACK_D > 1) ? $clog2(VSTACK_D) : 1;
   localparam int OAW = (OSTACK_D > 1) ? $clog2(OSTACK_D) : 1;

   localparam logic [VPW-1:0] VFULL = VPW'(VSTACK_D);
   localparam logic [OPW-1:0] OFULL = OPW'(OSTACK_D);

   localparam logic [2:0] K_NUM    = 3'd0;
   localparam logic [2:0] K_OP     = 3'd1;
   localparam logic [2:0] K_LPAREN = 3'd2;
   localparam logic [2:0] K_RPAREN = 3'd3;
   localparam logic [2:0] K_END    = 3'd4;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_EQ    = 4'd4;
   localparam logic [3:0] OP_NE    = 4'd5;
   localparam logic [3:0] OP_GT    = 4'd6;
   localparam logic [3:0] OP_GE    = 4'd7;
   localparam logic [3:0] OP_LT    = 4'd8;
   localparam logic [3:0] OP_LE    = 4'd9;
   localparam logic [3:0] OP_NEG   = 4'd10;
   // Paren marker reuses an opcode that can never be accepted as an operator
   localparam logic [3:0] OP_PAREN = 4'd15;

   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_VOVF    = 3'd1;
   localparam logic [2:0] E_OOVF    = 3'd2;
   localparam logic [2:0] E_SYNTAX  = 3'd3;
   localparam logic [2:0] E_DIV0    = 3'd4;
   localparam logic [2:0] E_PAREN   = 3'd5;
   localparam logic [2:0] E_ILLEGAL = 3'd6;

   typedef enum logic [2:0] {
      S_ACCEPT = 3'd0,
      S_REDUCE = 3'd1,
      S_DRAIN  = 3'd2,
      S_ERR    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                   state, state_nx;
   logic [VPW-1:0]           vsp, vsp_nx, vsp_m1, vsp_m2;
   logic [OPW-1:0]           osp, osp_nx, osp_m1, osp_m2;
   logic [DATA_W-1:0]        vstack [VSTACK_D];
   logic [3:0]               ostack [OSTACK_D];
   logic [3:0]               pend_op, pend_op_nx;
   logic                     pend_rp, pend_rp_nx;
   logic [2:0]               err_code, err_nx;
   logic                     res_load;
   logic [DATA_W-1:0]        res_data_nx;
   logic [2:0]               res_err_nx;
   logic                     v_we;
   logic [VAW-1:0]           v_addr;
   logic [DATA_W-1:0]        v_data;
   logic                     o_we;
   logic [OAW-1:0]           o_addr;
   logic [3:0]               o_data;
   logic [3:0]               top_op, below_op;
   logic signed [DATA_W-1:0] val_a, val_b;
   logic [DATA_W-1:0]        alu_res;
   logic                     is_neg, short_ops, div_zero, do_apply;
   logic [2:0]               app_err;
   logic [VAW-1:0]           app_addr;
   logic [VPW-1:0]           app_vsp;
   logic                     top_ge_tok, below_ge_pend;

   function automatic logic [2:0] prec(input logic [3:0] op);
      case (op)
         OP_EQ, OP_NE:               prec = 3'd1;
         OP_GT, OP_GE, OP_LT, OP_LE: prec = 3'd2;
         OP_ADD, OP_SUB:             prec = 3'd3;
         OP_MUL, OP_DIV:             prec = 3'd4;
         OP_NEG:                     prec = 3'd5;
         default:                    prec = 3'd0;
      endcase
   endfunction

   assign vsp_m1   = vsp - VPW'(1);
   assign vsp_m2   = vsp - VPW'(2);
   assign osp_m1   = osp - OPW'(1);
   assign osp_m2   = osp - OPW'(2);
   assign top_op   = ostack[osp_m1[OAW-1:0]];
   assign below_op = ostack[osp_m2[OAW-1:0]];
   assign val_b    = vstack[vsp_m1[VAW-1:0]];
   assign val_a    = vstack[vsp_m2[VAW-1:0]];

   assign top_ge_tok    = (osp != '0) && (prec(top_op) >= prec(tok_op));
   assign below_ge_pend = (osp_m1 != '0) && (prec(below_op) >= prec(pend_op));

   always_comb begin
      alu_res = '0;
      case (top_op)
         OP_ADD: alu_res = val_a + val_b;
         OP_SUB: alu_res = val_a - val_b;
         OP_MUL: alu_res = val_a * val_b;
         OP_DIV: begin
            // MIN / -1 would overflow the divider; negation wraps to MIN as required
            if (val_b == '1)
               alu_res = '0 - val_a;
            else if (val_b != '0)
               alu_res = val_a / val_b;
         end
         OP_EQ:  alu_res = DATA_W'(val_a == val_b);
         OP_NE:  alu_res = DATA_W'(val_a != val_b);
         OP_GT:  alu_res = DATA_W'(val_a > val_b);
         OP_GE:  alu_res = DATA_W'(val_a >= val_b);
         OP_LT:  alu_res = DATA_W'(val_a < val_b);
         OP_LE:  alu_res = DATA_W'(val_a <= val_b);
         OP_NEG: alu_res = '0 - val_b;
         default: alu_res = '0;
      endcase
   end

   assign is_neg    = (top_op == OP_NEG);
   assign short_ops = is_neg ? (vsp == '0) : (vsp < VPW'(2));
   assign div_zero  = (top_op == OP_DIV) && (val_b == '0);
   assign app_err   = short_ops ? E_SYNTAX : (div_zero ? E_DIV0 : E_NONE);
   assign app_addr  = is_neg ? vsp_m1[VAW-1:0] : vsp_m2[VAW-1:0];
   assign app_vsp   = is_neg ? vsp : vsp_m1;

   always_comb begin
      state_nx    = state;
      vsp_nx      = vsp;
      osp_nx      = osp;
      pend_op_nx  = pend_op;
      pend_rp_nx  = pend_rp;
      err_nx      = err_code;
      res_load    = 1'b0;
      res_data_nx = '0;
      res_err_nx  = E_NONE;
      v_we        = 1'b0;
      v_addr      = vsp[VAW-1:0];
      v_data      = tok_num;
      o_we        = 1'b0;
      o_addr      = osp[OAW-1:0];
      o_data      = tok_op;
      do_apply    = 1'b0;
      tok_ready   = 1'b0;
      res_valid   = 1'b0;

      case (state)
         S_ACCEPT: begin
            tok_ready = ~abort;
            if (tok_valid) begin
               case (tok_kind)
                  K_NUM: begin
                     if (vsp == VFULL) begin
                        state_nx = S_ERR;
                        err_nx   = E_VOVF;
                     end else begin
                        v_we   = 1'b1;
                        vsp_nx = vsp + VPW'(1);
                     end
                  end
                  K_LPAREN: begin
                     if (osp == OFULL) begin
                        state_nx = S_ERR;
                        err_nx   = E_OOVF;
                     end else begin
                        o_we   = 1'b1;
                        o_data = OP_PAREN;
                        osp_nx = osp + OPW'(1);
                     end
                  end
                  K_OP: begin
                     if (tok_op > OP_NEG) begin
                        state_nx = S_ERR;
                        err_nx   = E_ILLEGAL;
                     end else if (tok_op != OP_NEG && top_ge_tok) begin
                        pend_op_nx = tok_op;
                        pend_rp_nx = 1'b0;
                        state_nx   = S_REDUCE;
                     end else if (osp == OFULL) begin
                        state_nx = S_ERR;
                        err_nx   = E_OOVF;
                     end else begin
                        o_we   = 1'b1;
                        osp_nx = osp + OPW'(1);
                     end
                  end
                  K_RPAREN: begin
                     if (osp == '0) begin
                        state_nx = S_ERR;
                        err_nx   = E_PAREN;
                     end else begin
                        pend_rp_nx = 1'b1;
                        state_nx   = S_REDUCE;
                     end
                  end
                  K_END:   state_nx = S_DRAIN;
                  default: begin
                     state_nx = S_ERR;
                     err_nx   = E_ILLEGAL;
                  end
               endcase
            end
         end

         S_REDUCE: begin
            if (pend_rp) begin
               if (osp == '0) begin
                  state_nx = S_ERR;
                  err_nx   = E_PAREN;
               end else if (top_op == OP_PAREN) begin
                  osp_nx   = osp_m1;
                  state_nx = S_ACCEPT;
               end else begin
                  do_apply = 1'b1;
                  osp_nx   = osp_m1;
               end
            end else begin
               do_apply = 1'b1;
               if (below_ge_pend) begin
                  osp_nx = osp_m1;
               end else begin
                  // Pop and push land in the same slot, so depth is unchanged
                  o_we     = 1'b1;
                  o_addr   = osp_m1[OAW-1:0];
                  o_data   = pend_op;
                  osp_nx   = osp;
                  state_nx = S_ACCEPT;
               end
            end
         end

         S_DRAIN: begin
            if (osp == '0) begin
               if (vsp != VPW'(1)) begin
                  state_nx = S_ERR;
                  err_nx   = E_SYNTAX;
               end else begin
                  res_load    = 1'b1;
                  res_data_nx = val_b;
                  res_err_nx  = E_NONE;
                  vsp_nx      = '0;
                  state_nx    = S_DONE;
               end
            end else if (top_op == OP_PAREN) begin
               state_nx = S_ERR;
               err_nx   = E_PAREN;
            end else begin
               do_apply = 1'b1;
               osp_nx   = osp_m1;
            end
         end

         S_ERR: begin
            res_load    = 1'b1;
            res_data_nx = '0;
            res_err_nx  = err_code;
            vsp_nx      = '0;
            osp_nx      = '0;
            state_nx    = S_DONE;
         end

         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               vsp_nx   = '0;
               osp_nx   = '0;
               state_nx = S_ACCEPT;
            end
         end

         default: state_nx = S_ACCEPT;
      endcase

      if (do_apply) begin
         if (app_err != E_NONE) begin
            state_nx = S_ERR;
            err_nx   = app_err;
            o_we     = 1'b0;
            osp_nx   = osp;
         end else begin
            v_we   = 1'b1;
            v_addr = app_addr;
            v_data = alu_res;
            vsp_nx = app_vsp;
         end
      end

      if (abort) begin
         state_nx   = S_ACCEPT;
         vsp_nx     = '0;
         osp_nx     = '0;
         pend_rp_nx = 1'b0;
         v_we       = 1'b0;
         o_we       = 1'b0;
         res_load   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_ACCEPT;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsp      <= '0;
         osp      <= '0;
         pend_op  <= OP_ADD;
         pend_rp  <= 1'b0;
         err_code <= E_NONE;
         res_data <= '0;
         res_err  <= E_NONE;
      end else begin
         vsp      <= vsp_nx;
         osp      <= osp_nx;
         pend_op  <= pend_op_nx;
         pend_rp  <= pend_rp_nx;
         err_code <= err_nx;
         if (res_load) begin
            res_data <= res_data_nx;
            res_err  <= res_err_nx;
         end
      end
   end

   // Stack storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (v_we)
         vstack[v_addr] <= v_data;
      if (o_we)
         ostack[o_addr] <= o_data;
   end

endmodule
`default_nettype wire
